// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage program counter.
// Holds the pending-redirect encoding and the next-PC source priority.
package pc_pkg;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_BR,
        PEND_TRAP
    } pend_state_t;

    // Next-PC sources, listed highest priority first.
    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_PEND_TRAP,
        SEL_BRANCH,
        SEL_PEND_BR,
        SEL_SEQ
    } pc_sel_t;

    localparam int unsigned PC_XLEN_DEFAULT         = 32;
    localparam int          PC_RESET_VECTOR_DEFAULT = -4;
    localparam int unsigned PC_INC_DEFAULT          = 4;

    function automatic pc_sel_t pc_select(input logic trap, input logic branch,
                                          input pend_state_t pend);
        pc_sel_t sel;
        if (trap)                    sel = SEL_TRAP;
        else if (pend == PEND_TRAP)  sel = SEL_PEND_TRAP;
        else if (branch)             sel = SEL_BRANCH;
        else if (pend == PEND_BR)    sel = SEL_PEND_BR;
        else                         sel = SEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// One-entry buffer that keeps a redirect alive while fetch is held.
// A trap always wins; a branch never displaces a pending trap.
module pc_redirect_buffer
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = PC_XLEN_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              hold,
    input  logic              trap,
    input  logic [XLEN-1:0]   trap_target,
    input  logic              branch,
    input  logic [XLEN-1:0]   branch_target,
    output pend_state_t       state,
    output logic [XLEN-1:0]   target,
    output logic              pending
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= PEND_NONE;
            target  <= '0;
            pending <= 1'b0;
        end else if (!hold) begin
            // Any pending entry is consumed by the PC mux on an unheld edge.
            state   <= PEND_NONE;
            pending <= 1'b0;
        end else if (trap) begin
            state   <= PEND_TRAP;
            target  <= trap_target;
            pending <= 1'b1;
        end else if (branch && state != PEND_TRAP) begin
            state   <= PEND_BR;
            target  <= branch_target;
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage program counter with registered PC+INC, prioritised redirects
// and a pending-redirect buffer covering BUSYWAIT/STALL holds.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = PC_XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
    parameter int unsigned      INC          = PC_INC_DEFAULT,
    parameter int unsigned      ALIGN_BITS   = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BUSYWAIT,
    input  logic              STALL,
    input  logic              BRANCH_TAKEN,
    input  logic [XLEN-1:0]   BRANCH_TARGET,
    input  logic              TRAP,
    input  logic [XLEN-1:0]   TRAP_VECTOR,
    output logic [XLEN-1:0]   PC,
    output logic [XLEN-1:0]   PC_NEXT_SEQ,
    output logic              FLUSH,
    output logic              REDIRECT_PENDING
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    logic              hold;
    logic [XLEN-1:0]   br_tgt;
    logic [XLEN-1:0]   trap_tgt;
    pend_state_t       pend_state;
    logic [XLEN-1:0]   pend_target;
    pc_sel_t           sel;
    logic              redirect;
    logic [XLEN-1:0]   redirect_target;

    assign hold     = BUSYWAIT | STALL;
    assign br_tgt   = BRANCH_TARGET & ALIGN_MASK;
    assign trap_tgt = TRAP_VECTOR & ALIGN_MASK;

    pc_redirect_buffer #(
        .XLEN (XLEN)
    ) u_redirect_buffer (
        .CLK           (CLK),
        .RESET         (RESET),
        .hold          (hold),
        .trap          (TRAP),
        .trap_target   (trap_tgt),
        .branch        (BRANCH_TAKEN),
        .branch_target (br_tgt),
        .state         (pend_state),
        .target        (pend_target),
        .pending       (REDIRECT_PENDING)
    );

    always_comb begin
        sel             = pc_select(TRAP, BRANCH_TAKEN, pend_state);
        redirect        = 1'b1;
        redirect_target = '0;
        case (sel)
            SEL_TRAP:      redirect_target = trap_tgt;
            SEL_PEND_TRAP: redirect_target = pend_target;
            SEL_BRANCH:    redirect_target = br_tgt;
            SEL_PEND_BR:   redirect_target = pend_target;
            default:       redirect        = 1'b0;
        endcase
    end

    // PC_NEXT_SEQ is kept one step ahead so the sequential path is a plain copy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC          <= RESET_VECTOR;
            PC_NEXT_SEQ <= RESET_VECTOR + STEP;
            FLUSH       <= 1'b0;
        end else if (!hold) begin
            if (redirect) begin
                PC          <= redirect_target;
                PC_NEXT_SEQ <= redirect_target + STEP;
                FLUSH       <= 1'b1;
            end else begin
                PC          <= PC_NEXT_SEQ;
                PC_NEXT_SEQ <= PC_NEXT_SEQ + STEP;
                FLUSH       <= 1'b0;
            end
        end else begin
            FLUSH <= 1'b0;
        end
    end

endmodule
